// File: rtl/dma_uart.sv
// dma_uart: single-word DMA between cache and host over an 8N1 UART link; read path enabled by DMA_UART_READ_EN
module dma_uart #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] instr,
    output logic        busy,
    output logic [57:0] cache_write_port,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LEAD = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {S_IDLE, S_TX_CMD, S_TX_HI, S_TX_LO, S_RX_HI, S_RX_LO, S_CACHE_WR} state_t;

`ifdef DMA_UART_READ_EN
    localparam state_t AFTER_RD_CMD = S_RX_HI;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t rx_state_q, rx_state_d;
    logic [2:0] rx_sync_q, rx_sync_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic rx_done_q, rx_done_d;
    logic [7:0] b1_q, b1_d;
    logic [57:0] cwp_q, cwp_d;
`else
    localparam state_t AFTER_RD_CMD = S_IDLE;
`endif

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [39:0] instr_q, instr_d;
    logic txd_q, txd_d;
    logic tx_active;
    logic [7:0] tx_byte;
    logic [2:0] tx_idx;

    // Transaction sequencing and bit timing; bit index 10 is the one idle lead cycle before the first start bit
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        instr_d = instr_q;
`ifdef DMA_UART_READ_EN
        b1_d = b1_q;
        cwp_d = cwp_q;
        cwp_d[21] = 1'b0;
`endif
        if (state_q == S_IDLE && instr[21]) begin
            state_d = S_TX_CMD;
            instr_d = instr;
            cnt_d = LEAD;
            bit_d = 4'd10;
        end else if (state_q inside {S_TX_CMD, S_TX_HI, S_TX_LO}) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) bit_d = (bit_q >= 4'd9) ? 4'd0 : bit_q + 4'd1;
            if (cnt_q == LAST && bit_q == 4'd9)
                state_d = (state_q == S_TX_HI) ? S_TX_LO : (state_q == S_TX_LO) ? S_IDLE : instr_q[20] ? S_TX_HI : AFTER_RD_CMD;
        end
`ifdef DMA_UART_READ_EN
        else if (state_q == S_RX_HI && rx_done_q) begin
            b1_d = rx_byte_q;
            state_d = S_RX_LO;
        end else if (state_q == S_RX_LO && rx_done_q) begin
            state_d = S_CACHE_WR;
            cwp_d = {b1_q, rx_byte_q, 2'b00, instr_q[39:22], 2'b10, instr_q[19:0]};
        end else if (state_q == S_CACHE_WR) begin
            state_d = S_IDLE;
        end
`endif
        tx_active = state_d inside {S_TX_CMD, S_TX_HI, S_TX_LO};
        tx_byte = (state_d == S_TX_HI) ? instr_d[39:32] : (state_d == S_TX_LO) ? instr_d[31:24] : instr_d[20:13];
        tx_idx = 3'(bit_d - 4'd1);
        txd_d = (!tx_active || bit_d >= 4'd9) ? 1'b1 : (bit_d == 4'd0) ? 1'b0 : tx_byte[tx_idx];
    end

    // Main state, bit timer and registered TX line; reset parks the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            instr_q <= '0;
            txd_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            instr_q <= instr_d;
            txd_q <= txd_d;
        end
    end

    assign busy = state_q != S_IDLE;
    assign uart_txd = txd_q;

`ifdef DMA_UART_READ_EN
    // Receiver: sync[1] is the synchronized line, sync[2] its previous value for start-edge detection
    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], uart_rxd};
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_byte_d = rx_byte_q;
        rx_done_d = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync_q[2] && !rx_sync_q[1]) rx_state_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_state_d = rx_sync_q[1] ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_byte_d = {rx_sync_q[1], rx_byte_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end
            default: if (rx_cnt_q == LAST) begin
                rx_done_d = rx_sync_q[1];
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // Receiver registers, first reply byte and cache write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            rx_sync_q <= 3'b111;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_byte_q <= '0;
            rx_done_q <= 1'b0;
            b1_q <= '0;
            cwp_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sync_q <= rx_sync_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_byte_q <= rx_byte_d;
            rx_done_q <= rx_done_d;
            b1_q <= b1_d;
            cwp_q <= cwp_d;
        end
    end

    assign cache_write_port = cwp_q;
`else
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign cache_write_port = '0;
`endif
endmodule

// File: tb/tb_dma_uart.sv
// tb_dma_uart: table-driven and scoreboard checks of dma_uart framing, busy timing and read path
module tb_dma_uart;
    localparam int C = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_rxd = 1'b1;
    logic uart_txd;
    logic busy;
    logic [39:0] instr = '0;
    logic [57:0] cwp;
    int n_chk = 0;
    int n_fail = 0;
    logic exp_q[$];

    typedef struct {
        logic [17:0] dat;
        logic [6:0] addr;
        logic [1:0] slot;
        logic [10:0] caddr;
        bit poke;
        logic [7:0] cmd;
        logic [7:0] hi;
        logic [7:0] lo;
    } wr_t;

    typedef struct {
        logic [6:0] addr;
        logic [1:0] slot;
        logic [10:0] caddr;
        bit bad_first;
        logic [7:0] h1;
        logic [7:0] h2;
        logic [7:0] cmd;
        logic [17:0] dat;
    } rd_t;

    wr_t wv[4];
    rd_t rv[2];
    logic [39:0] w;
    logic [57:0] cap;
    logic got, after_v, after_b, ok;

    dma_uart #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .instr(instr), .busy(busy),
        .cache_write_port(cwp), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic host_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            uart_rxd = b[i];
        end
        repeat (C) @(negedge clk);
        uart_rxd = stop;
        repeat (C) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic run_tx(input logic [39:0] wi, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int nbytes, input bit poke, input int abort_k, input bit keep_busy);
        logic e;
        push_frame(b0);
        if (nbytes > 1) begin
            push_frame(b1);
            push_frame(b2);
        end
        @(negedge clk) instr = wi;
        @(posedge clk) #1 instr = '0;
        chk("busy_at_accept", 64'(busy), 64'(1));
        chk("txd_lead_cycle", 64'(uart_txd), 64'(1));
        repeat (2 + C / 2) @(posedge clk);
        #1;
        for (int k = 0; k < nbytes * 10; k++) begin
            if (k > 0) begin
                if (poke && k == 12) begin
                    @(negedge clk) instr = {wi[39:20], ~wi[19:13], wi[12:0]};
                    @(posedge clk) #1 instr = '0;
                    repeat (C - 1) @(posedge clk);
                end else begin
                    repeat (C) @(posedge clk);
                end
                #1;
            end
            e = exp_q.pop_front();
            chk($sformatf("txd_bit%0d", k), 64'(uart_txd), 64'(e));
            if (k == nbytes * 10 - 2) chk("busy_last_data", 64'(busy), 64'(1));
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                chk("abort_txd", 64'(uart_txd), 64'(1));
                chk("abort_busy", 64'(busy), 64'(0));
                exp_q.delete();
                @(negedge clk) reset = 1'b1;
                return;
            end
        end
        if (keep_busy) return;
        repeat (C - C / 2 - 1) @(posedge clk);
        #1 chk("busy_in_stop", 64'(busy), 64'(1));
        @(posedge clk) #1;
        chk("busy_fall", 64'(busy), 64'(0));
        chk("txd_idle_after", 64'(uart_txd), 64'(1));
    endtask

    initial begin
        wv[0] = '{18'b110101110100010101, 7'b0011001, 2'd1, 11'h00A, 1'b0, 8'h99, 8'hD7, 8'h45};
        wv[1] = '{18'h3FFFF, 7'h7F, 2'd3, 11'h7FF, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        wv[2] = '{18'h00003, 7'h00, 2'd0, 11'h000, 1'b0, 8'h80, 8'h00, 8'h00};
        wv[3] = '{18'h12345, 7'h55, 2'd2, 11'h155, 1'b1, 8'hD5, 8'h48, 8'hD1};
        rv[0] = '{7'h00, 2'd2, 11'h123, 1'b0, 8'h05, 8'h39, 8'h00, 18'h014E4};
        rv[1] = '{7'h2A, 2'd1, 11'h7FF, 1'b1, 8'hA5, 8'hC3, 8'h2A, 18'h2970C};

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_txd", 64'(uart_txd), 64'(1));
        chk("reset_cwp", 64'(cwp), 64'(0));

        for (int i = 0; i < 4; i++) begin
            w = {wv[i].dat, 1'b1, 1'b1, wv[i].addr, wv[i].slot, wv[i].caddr};
            run_tx(w, wv[i].cmd, wv[i].hi, wv[i].lo, 3, wv[i].poke, -1, 1'b0);
        end
        ok = 1'b1;
        repeat (3 * C) begin
            @(posedge clk) #1;
            if (busy || !uart_txd) ok = 1'b0;
        end
        chk("no_second_txn", 64'(ok), 64'(1));
        chk("cwp_after_writes", 64'(cwp), 64'(0));

        w = {wv[0].dat, 1'b1, 1'b1, wv[0].addr, wv[0].slot, wv[0].caddr};
        run_tx(w, wv[0].cmd, wv[0].hi, wv[0].lo, 3, 1'b0, 13, 1'b0);
        run_tx(w, wv[0].cmd, wv[0].hi, wv[0].lo, 3, 1'b0, -1, 1'b0);

`ifdef DMA_UART_READ_EN
        for (int i = 0; i < 2; i++) begin
            w = {18'h0, 1'b1, 1'b0, rv[i].addr, rv[i].slot, rv[i].caddr};
            run_tx(w, rv[i].cmd, 8'h00, 8'h00, 1, 1'b0, -1, 1'b1);
            got = 1'b0;
            after_v = 1'b1;
            after_b = 1'b1;
            cap = '0;
            fork
                begin
                    repeat (C) @(negedge clk);
                    if (rv[i].bad_first) begin
                        host_byte(8'h77, 1'b0);
                        repeat (2 * C) @(negedge clk);
                    end
                    host_byte(rv[i].h1, 1'b1);
                    host_byte(rv[i].h2, 1'b1);
                end
                begin
                    for (int c = 0; c < 60 * C && !got; c++) begin
                        @(posedge clk) #1;
                        if (cwp[21]) begin
                            got = 1'b1;
                            cap = cwp;
                            @(posedge clk) #1;
                            after_v = cwp[21];
                            after_b = busy;
                        end
                    end
                end
            join
            chk("rd_strobe_seen", 64'(got), 64'(1));
            chk("rd_cwp", 64'(cap), 64'({rv[i].dat, w}));
            chk("rd_valid_one_cycle", 64'(after_v), 64'(0));
            chk("rd_busy_after", 64'(after_b), 64'(0));
            ok = 1'b1;
            repeat (2 * C) begin
                @(posedge clk) #1;
                if (cwp[21] || busy) ok = 1'b0;
            end
            chk("rd_no_extra_strobe", 64'(ok), 64'(1));
        end
`else
        w = {18'h0, 1'b1, 1'b0, 7'h2A, 2'd1, 11'h7FF};
        run_tx(w, 8'h2A, 8'h00, 8'h00, 1, 1'b0, -1, 1'b0);
        chk("rd_cwp_zero", 64'(cwp), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
